uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Serial-to-parallel UART receive path. Sits downstream of the UART transmitter across the serial link.
//   Frame format matches the transmitter: start bit, 8 data bits LSB first, optional parity, then stop bits.
//   Oversamples the line with the shared baud-rate sample_tick, samples each bit at mid-bit and checks parity and stop bits.
//   Holds each received word with a valid/read handshake and reports overrun.
// PARAMETERS
//   TICKS_PER_BIT  4  sample_tick pulses per bit period; must equal the transmitter's value (4). Even, >=4.
//   SYNC_STAGES    2  flip-flop stages in the rx input synchronizer; >=2.
// PORTS
//   clk            in   1  system clock
//   resetn         in   1  asynchronous, active-low reset
//   sample_tick    in   1  one-cycle strobe from the baud-rate generator
//   PARITY_MODE    in   2  0/3 = none, 1 = odd, 2 = even (same coding as the transmitter)
//   STOP_BITS      in   2  stop bits checked = min(STOP_BITS,2)+1
//   rx             in   1  serial line, asynchronous to clk, idles high
//   rx_read        in   1  consumer pops the held word
//   rx_data        out  8  last received data byte
//   rx_valid       out  1  rx_data holds an unread word
//   rx_done        out  1  one-cycle pulse per completed frame, including errored frames
//   parity_error   out  1  parity mismatch in the held frame
//   framing_error  out  1  a checked stop bit sampled low in the held frame
//   overrun_error  out  1  sticky: a frame completed while rx_valid=1 and rx_read=0
// BEHAVIOUR
//   Reset: all synchronizer flops =1; state=IDLE; counters=0.
//     Outputs: rx_data=0, rx_valid=0, rx_done=0, all error flags=0.
//     Reset mid-frame aborts the frame; no rx_done is generated.
//   rx_s is the synchronized rx. All decisions use rx_s only.
//   PARITY_MODE and STOP_BITS are latched on start detection. Changes mid-frame have no effect.
//   tick counter: advances only on sample_tick. H = TICKS_PER_BIT/2, T = TICKS_PER_BIT.
//   States:
//     IDLE:   on a falling edge of rx_s (previous 1, current 0) -> START, tick=0.
//             A line held low never retriggers; a new frame needs a return to 1 first.
//     START:  on the sample_tick with tick==H-1, check rx_s:
//               rx_s=0 -> DATA, tick=0, bit count=0.
//               rx_s=1 -> IDLE; glitch rejected, no rx_done, no flags.
//     DATA:   on the sample_tick with tick==T-1, shift rx_s into bit 7 of the shift register (LSB first), tick=0.
//             After the 8th bit -> PARITY if parity is enabled, else STOP.
//     PARITY: sample at tick==T-1.
//               odd:  error if ^{data,p}==0.
//               even: error if ^{data,p}==1.
//             -> STOP.
//     STOP:   sample each checked stop bit at tick==T-1.
//               rx_s=0 -> complete immediately with framing error, -> IDLE.
//               Last checked stop bit =1 -> complete, -> IDLE.
//   Completion (registered, the cycle after the deciding sample_tick):
//     rx_data <= shift reg; parity_error, framing_error <= this frame's results; rx_valid <= 1; rx_done = 1 for one cycle.
//     If rx_valid=1 and rx_read=0 in the completion cycle: overrun_error <= 1 and the data is overwritten.
//     If rx_read=1 in the completion cycle: the new word is valid and there is no overrun.
//   Read: rx_read with rx_valid=1 and no completion that cycle.
//     Next cycle: rx_valid=0, overrun_error=0. rx_data and the other flags hold.
//     rx_read with rx_valid=0 is ignored.
//   Latency: rx_done occurs SYNC_STAGES+1 clocks after the deciding sample_tick, measured from the rx edge at that position.
//     Relative to the line, this is roughly 0.5 bit period after the start of the last checked stop bit.
//   sample_tick ignored in IDLE. An rx edge on a cycle without sample_tick only matters in IDLE.
// TESTING
//   (Loopback with the transmitter: tx->rx, same sample_tick and configuration.)
//   1. No parity, 1 stop: send 8'hA5 -> one rx_done, rx_data=8'hA5, rx_valid=1, all error flags=0.
//   2. Odd parity: send 8'h00 with parity bit 1 -> no parity_error.
//      Force the parity bit to 0 -> parity_error=1, rx_data=8'h00.
//   3. Glitch: rx low for 1 sample_tick then high -> no rx_done, state returns to IDLE.
//      Following valid 8'h3C received correctly.
//   4. Framing: STOP_BITS=1, drive the 2nd stop bit low -> framing_error=1 and rx_done.
//      Line held low -> no new frame until rx returns high.
//   5. Overrun: receive 8'h11, no rx_read, then receive 8'h22 -> rx_data=8'h22, overrun_error=1.
//      Pulse rx_read -> rx_valid=0, overrun_error=0.
//      Second case: rx_read in the completion cycle -> no overrun.
//   6. Assert resetn=0 mid-DATA -> all outputs 0, no rx_done.
//      After release, 8'hFF with even parity, STOP_BITS=2 -> received cleanly.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive path: synchronizes rx, finds the start bit, samples each bit at
// mid-bit on sample_tick, checks parity/stop bits and holds the word for a reader.
module uart_receiver #(
    parameter int TICKS_PER_BIT = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sample_tick,
    input  logic [1:0] PARITY_MODE,
    input  logic [1:0] STOP_BITS,
    input  logic       rx,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_done,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun_error
);

    localparam int TW = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Input synchronizer; resets to the idle (high) line level.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   w_rx_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rx_prev <= w_rx_s;
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_tick, w_tick_next;
    logic [2:0]    r_bit_cnt, w_bit_cnt_next;
    logic [1:0]    r_stop_cnt, w_stop_cnt_next;
    logic [1:0]    r_stop_last, w_stop_last_next;
    logic [1:0]    r_par_mode, w_par_mode_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_par_err, w_par_err_next;
    logic          w_par_en;
    logic          w_par_xor;
    logic          w_complete;
    logic          w_frame_ferr;

    assign w_par_en  = (r_par_mode == 2'd1) || (r_par_mode == 2'd2);
    assign w_par_xor = ^{r_shift, w_rx_s};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= '0;
            r_stop_last <= '0;
            r_par_mode  <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tick      <= w_tick_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_stop_cnt  <= w_stop_cnt_next;
            r_stop_last <= w_stop_last_next;
            r_par_mode  <= w_par_mode_next;
            r_shift     <= w_shift_next;
            r_par_err   <= w_par_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_tick_next      = r_tick;
        w_bit_cnt_next   = r_bit_cnt;
        w_stop_cnt_next  = r_stop_cnt;
        w_stop_last_next = r_stop_last;
        w_par_mode_next  = r_par_mode;
        w_shift_next     = r_shift;
        w_par_err_next   = r_par_err;
        w_complete       = 1'b0;
        w_frame_ferr     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Edge-triggered so a line stuck low cannot start frame after frame.
                if (r_rx_prev && !w_rx_s) begin
                    w_state_next     = S_START;
                    w_tick_next      = '0;
                    w_par_mode_next  = PARITY_MODE;
                    w_stop_last_next = (STOP_BITS == 2'd3) ? 2'd2 : STOP_BITS;
                    w_par_err_next   = 1'b0;
                end
            end

            S_START: begin
                if (sample_tick) begin
                    if (r_tick == TICK_HALF) begin
                        if (!w_rx_s) begin
                            w_state_next   = S_DATA;
                            w_tick_next    = '0;
                            w_bit_cnt_next = '0;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_tick_next = r_tick + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (sample_tick) begin
                    if (r_tick == TICK_LAST) begin
                        w_shift_next = {w_rx_s, r_shift[7:1]};
                        w_tick_next  = '0;
                        if (r_bit_cnt == 3'd7) begin
                            w_stop_cnt_next = '0;
                            w_state_next    = w_par_en ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 3'd1;
                        end
                    end else begin
                        w_tick_next = r_tick + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (sample_tick) begin
                    if (r_tick == TICK_LAST) begin
                        w_par_err_next  = (r_par_mode == 2'd1) ? !w_par_xor : w_par_xor;
                        w_tick_next     = '0;
                        w_stop_cnt_next = '0;
                        w_state_next    = S_STOP;
                    end else begin
                        w_tick_next = r_tick + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (sample_tick) begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_next = '0;
                        if (!w_rx_s) begin
                            w_complete   = 1'b1;
                            w_frame_ferr = 1'b1;
                            w_state_next = S_IDLE;
                        end else if (r_stop_cnt == r_stop_last) begin
                            w_complete   = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_stop_cnt_next = r_stop_cnt + 2'd1;
                        end
                    end else begin
                        w_tick_next = r_tick + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output holding register; a completing frame takes priority over a read.
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_done;
    logic       r_parity_error;
    logic       r_framing_error;
    logic       r_overrun_error;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_rx_done       <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
        end else begin
            r_rx_done <= w_complete;
            if (w_complete) begin
                r_rx_data       <= r_shift;
                r_parity_error  <= r_par_err;
                r_framing_error <= w_frame_ferr;
                r_rx_valid      <= 1'b1;
                if (r_rx_valid && !rx_read) begin
                    r_overrun_error <= 1'b1;
                end
            end else if (rx_read && r_rx_valid) begin
                r_rx_valid      <= 1'b0;
                r_overrun_error <= 1'b0;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_done       = r_rx_done;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;
    assign overrun_error = r_overrun_error;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven bit by bit with four
// sample_tick slots per bit and four clocks per slot.
module tb_uart_receiver;

    logic       clk;
    logic       resetn;
    logic       sample_tick;
    logic [1:0] PARITY_MODE;
    logic [1:0] STOP_BITS;
    logic       rx;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_done;
    logic       parity_error;
    logic       framing_error;
    logic       overrun_error;

    int checks   = 0;
    int failures = 0;
    int done_count = 0;

    uart_receiver #(
        .TICKS_PER_BIT(4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sample_tick  (sample_tick),
        .PARITY_MODE  (PARITY_MODE),
        .STOP_BITS    (STOP_BITS),
        .rx           (rx),
        .rx_read      (rx_read),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_done      (rx_done),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done === 1'b1) done_count++;
    end

    // Frame bits LSB first: start, data, optional parity, then stop bits (all 1).
    function automatic logic [15:0] mk_frame(input logic [7:0] d, input logic has_par, input logic p);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (has_par) f[9] = p;
        return f;
    endfunction

    // The deciding sample of a bit falls on its slot-2 tick, so a completing
    // last bit shows rx_done at the negedge right after that tick's posedge.
    task automatic send_bits(input logic [15:0] bits, input int nbits, input logic read_last,
                             output logic done_at_last);
        done_at_last = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    rx          = bits[b];
                    sample_tick = (c == 0);
                    rx_read     = read_last && (b == nbits - 1) && (s == 2) && (c == 0);
                    @(negedge clk);
                    if ((b == nbits - 1) && (s == 2) && (c == 0)) done_at_last = rx_done;
                end
            end
        end
        sample_tick = 1'b0;
        rx_read     = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        sample_tick = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
        checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", rx_done); end
        checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b want=0", parity_error); end
        checks++; if (framing_error !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b want=0", framing_error); end
        checks++; if (overrun_error !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b want=0", overrun_error); end
        resetn = 1'b1;
        idle(6);
        $display("reset released");
    endtask

    task automatic test_basic();
        int   d0;
        logic dl;
        PARITY_MODE = 2'd0;
        STOP_BITS   = 2'd0;
        d0 = done_count;
        send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 10, 1'b0, dl);
        idle(4);
        $display("frame data=a5 parity=none stop=1 rx_data=%h", rx_data);
        checks++; if (done_count !== d0 + 1) begin failures++; $display("FAIL basic_done_count got=%0d want=%0d", done_count, d0 + 1); end
        checks++; if (dl !== 1'b1) begin failures++; $display("FAIL basic_done_timing got=%b want=1", dl); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h want=a5", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", rx_valid); end
        checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL basic_perr got=%b want=0", parity_error); end
        checks++; if (framing_error !== 1'b0) begin failures++; $display("FAIL basic_ferr got=%b want=0", framing_error); end
        checks++; if (overrun_error !== 1'b0) begin failures++; $display("FAIL basic_ovr got=%b want=0", overrun_error); end
        do_read();
        $display("read rx_valid=%b", rx_valid);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL read_valid got=%b want=0", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL read_data_hold got=%h want=a5", rx_data); end
    endtask

    task automatic test_parity();
        logic dl;
        PARITY_MODE = 2'd1;
        STOP_BITS   = 2'd0;
        send_bits(mk_frame(8'h00, 1'b1, 1'b1), 11, 1'b0, dl);
        idle(4);
        $display("frame data=00 parity=odd pbit=1 perr=%b", parity_error);
        checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL odd_ok_perr got=%b want=0", parity_error); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL odd_ok_data got=%h want=00", rx_data); end
        do_read();
        send_bits(mk_frame(8'h00, 1'b1, 1'b0), 11, 1'b0, dl);
        idle(4);
        $display("frame data=00 parity=odd pbit=0 perr=%b", parity_error);
        checks++; if (parity_error !== 1'b1) begin failures++; $display("FAIL odd_bad_perr got=%b want=1", parity_error); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL odd_bad_data got=%h want=00", rx_data); end
        checks++; if (framing_error !== 1'b0) begin failures++; $display("FAIL odd_bad_ferr got=%b want=0", framing_error); end
        checks++; if (dl !== 1'b1) begin failures++; $display("FAIL odd_bad_done_timing got=%b want=1", dl); end
        do_read();
    endtask

    task automatic test_glitch();
        int   d0;
        logic dl;
        PARITY_MODE = 2'd0;
        STOP_BITS   = 2'd0;
        d0 = done_count;
        rx = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sample_tick = (c == 0);
            @(negedge clk);
        end
        rx = 1'b1;
        for (int c = 0; c < 12; c++) begin
            sample_tick = (c % 4 == 0);
            @(negedge clk);
        end
        idle(8);
        $display("glitch done_count=%0d", done_count);
        checks++; if (done_count !== d0) begin failures++; $display("FAIL glitch_no_done got=%0d want=%0d", done_count, d0); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b want=0", rx_valid); end
        send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 10, 1'b0, dl);
        idle(4);
        $display("frame data=3c after glitch rx_data=%h", rx_data);
        checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL glitch_next_data got=%h want=3c", rx_data); end
        checks++; if (done_count !== d0 + 1) begin failures++; $display("FAIL glitch_next_done got=%0d want=%0d", done_count, d0 + 1); end
        do_read();
    endtask

    task automatic test_framing();
        int          d0;
        logic        dl;
        logic [15:0] f;
        PARITY_MODE = 2'd0;
        STOP_BITS   = 2'd1;
        d0 = done_count;
        f = mk_frame(8'h5A, 1'b0, 1'b0);
        f[10] = 1'b0;
        send_bits(f, 11, 1'b0, dl);
        $display("frame data=5a stop2 low ferr=%b", framing_error);
        checks++; if (framing_error !== 1'b1) begin failures++; $display("FAIL frm_ferr got=%b want=1", framing_error); end
        checks++; if (dl !== 1'b1) begin failures++; $display("FAIL frm_done_timing got=%b want=1", dl); end
        checks++; if (done_count !== d0 + 1) begin failures++; $display("FAIL frm_done_count got=%0d want=%0d", done_count, d0 + 1); end
        checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL frm_data got=%h want=5a", rx_data); end
        checks++; if (parity_error !== 1'b0) begin failures++; $display("FAIL frm_perr got=%b want=0", parity_error); end
        send_bits(16'h0000, 12, 1'b0, dl);
        $display("line held low done_count=%0d", done_count);
        checks++; if (done_count !== d0 + 1) begin failures++; $display("FAIL frm_low_no_frame got=%0d want=%0d", done_count, d0 + 1); end
        idle(8);
        do_read();
        STOP_BITS = 2'd0;
        send_bits(mk_frame(8'h81, 1'b0, 1'b0), 10, 1'b0, dl);
        idle(4);
        $display("frame data=81 after low line rx_data=%h", rx_data);
        checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL frm_recover_data got=%h want=81", rx_data); end
        checks++; if (framing_error !== 1'b0) begin failures++; $display("FAIL frm_recover_ferr got=%b want=0", framing_error); end
        do_read();
    endtask

    task automatic test_overrun();
        logic dl;
        PARITY_MODE = 2'd0;
        STOP_BITS   = 2'd0;
        send_bits(mk_frame(8'h11, 1'b0, 1'b0), 10, 1'b0, dl);
        idle(4);
        send_bits(mk_frame(8'h22, 1'b0, 1'b0), 10, 1'b0, dl);
        idle(4);
        $display("frame data=22 unread 11 ovr=%b", overrun_error);
        checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL ovr_data got=%h want=22", rx_data); end
        checks++; if (overrun_error !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b want=1", overrun_error); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b want=1", rx_valid); end
        do_read();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_read_valid got=%b want=0", rx_valid); end
        checks++; if (overrun_error !== 1'b0) begin failures++; $display("FAIL ovr_read_clear got=%b want=0", overrun_error); end
        checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL ovr_read_data got=%h want=22", rx_data); end
        send_bits(mk_frame(8'h33, 1'b0, 1'b0), 10, 1'b0, dl);
        idle(4);
        send_bits(mk_frame(8'h44, 1'b0, 1'b0), 10, 1'b1, dl);
        idle(4);
        $display("frame data=44 read in completion cycle ovr=%b valid=%b", overrun_error, rx_valid);
        checks++; if (overrun_error !== 1'b0) begin failures++; $display("FAIL rdc_ovr got=%b want=0", overrun_error); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL rdc_valid got=%b want=1", rx_valid); end
        checks++; if (rx_data !== 8'h44) begin failures++; $display("FAIL rdc_data got=%h want=44", rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        int   d0;
        logic dl;
        PARITY_MODE = 2'd0;
        STOP_BITS   = 2'd0;
        send_bits(mk_frame(8'hC3, 1'b0, 1'b0), 5, 1'b0, dl);
        d0 = done_count;
        resetn = 1'b0;
        #1;
        $display("reset mid-frame rx_data=%h rx_valid=%b", rx_data, rx_valid);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h want=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", rx_valid); end
        checks++; if ({parity_error, framing_error, overrun_error, rx_done} !== 4'b0000) begin
            failures++; $display("FAIL mid_rst_flags got=%b want=0000", {parity_error, framing_error, overrun_error, rx_done});
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle(6);
        checks++; if (done_count !== d0) begin failures++; $display("FAIL mid_rst_no_done got=%0d want=%0d", done_count, d0); end
        PARITY_MODE = 2'd2;
        STOP_BITS   = 2'd2;
        send_bits(mk_frame(8'hFF, 1'b1, 1'b0), 13, 1'b0, dl);
        idle(4);
        $display("frame data=ff parity=even stop=3 rx_data=%h", rx_data);
        checks++; if (rx_data !== 8'hFF) begin failures++; $display("FAIL ff_data got=%h want=ff", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ff_valid got=%b want=1", rx_valid); end
        checks++; if ({parity_error, framing_error, overrun_error} !== 3'b000) begin
            failures++; $display("FAIL ff_flags got=%b want=000", {parity_error, framing_error, overrun_error});
        end
        checks++; if (dl !== 1'b1) begin failures++; $display("FAIL ff_done_timing got=%b want=1", dl); end
        checks++; if (done_count !== d0 + 1) begin failures++; $display("FAIL ff_done_count got=%0d want=%0d", done_count, d0 + 1); end
    endtask

    initial begin
        resetn      = 1'b0;
        sample_tick = 1'b0;
        PARITY_MODE = 2'd0;
        STOP_BITS   = 2'd0;
        rx          = 1'b1;
        rx_read     = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
